// File: rtl/issue_queue.sv
// issue_queue: unified out-of-order issue queue feeding ALU, MEM and BRANCH units.
// Holds renamed ops until both sources are ready, then issues one per cycle.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   write_enable, phys_*       dispatch request, tags and source values
//   opcode, immediate          instruction fields stored with the entry
//   ROB_entry_index            ROB tag carried to the issued op
//   fwd_*                      two writeback forwarding ports (tag + value)
//   fu_ready                   per-class accept (0=ALU, 1=MEM, 2=BRANCH)
//   issue_queue_full           queue holds NUM_INSTRUCTIONS entries
//   issue_*                    registered issue bundle, issue_valid strobes
module issue_queue #(
  parameter int NUM_FUNCTIONAL_UNITS = 3,
  parameter int NUM_PHYSICAL_REGS    = 64,
  parameter int NUM_INSTRUCTIONS     = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            write_enable,
  input  logic [5:0]                      phys_dest,
  input  logic [5:0]                      phys_rs1,
  input  logic [31:0]                     phys_rs1_val,
  input  logic [5:0]                      phys_rs2,
  input  logic [31:0]                     phys_rs2_val,
  input  logic [6:0]                      opcode,
  input  logic [31:0]                     immediate,
  input  logic [5:0]                      ROB_entry_index,
  input  logic [31:0]                     fwd_rs1,
  input  logic [31:0]                     fwd_rs2,
  input  logic [1:0]                      fwd_valid,
  input  logic [5:0]                      fwd_tag0,
  input  logic [5:0]                      fwd_tag1,
  input  logic [NUM_FUNCTIONAL_UNITS-1:0] fu_ready,
  output logic                            issue_queue_full,
  output logic                            issue_valid,
  output logic [1:0]                      issue_fu,
  output logic [6:0]                      issue_opcode,
  output logic [5:0]                      issue_dest,
  output logic [5:0]                      issue_rob,
  output logic [31:0]                     issue_rs1_val,
  output logic [31:0]                     issue_rs2_val,
  output logic [31:0]                     issue_imm
);

  localparam int IW = $clog2(NUM_INSTRUCTIONS);
  localparam int CW = IW + 1;

  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_MEM = 2'd1;
  localparam logic [1:0] FU_BR  = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [5:0]  rs1_tag;
    logic [5:0]  rs2_tag;
    logic        rs1_rdy;
    logic        rs2_rdy;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [5:0]  dest;
    logic [6:0]  opcode;
    logic [31:0] imm;
    logic [5:0]  rob;
    logic [1:0]  fu;
  } entry_t;

  function automatic logic [1:0] fu_class(input logic [6:0] op);
    logic       is_mem;
    logic       is_br;
    logic [1:0] c;
    is_mem = (op == 7'b0000011) || (op == 7'b0100011);
    is_br  = (op == 7'b1100011) || (op == 7'b1101111) ||
             (op == 7'b1100111);
    unique case (1'b1)
      is_mem:  c = FU_MEM;
      is_br:   c = FU_BR;
      default: c = FU_ALU;
    endcase
    return c;
  endfunction

  entry_t                       q [NUM_INSTRUCTIONS];
  logic [NUM_PHYSICAL_REGS-1:0] sb;
  logic [NUM_PHYSICAL_REGS-1:0] sb_n;
  logic [CW-1:0]                count;

  logic [3:0]    fu_rdy4;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] iss_idx;
  logic          iss_hit;
  logic          accept;
  entry_t        new_e;

  assign issue_queue_full = (count == CW'(NUM_INSTRUCTIONS));
  assign accept = write_enable && !issue_queue_full;

  // Widen so a 2-bit class index never falls outside the vector.
  always_comb begin
    fu_rdy4 = '0;
    fu_rdy4[NUM_FUNCTIONAL_UNITS-1:0] = fu_ready;
  end

  // Downward scan: the last hit is the lowest index.
  always_comb begin
    free_idx = '0;
    iss_idx  = '0;
    iss_hit  = 1'b0;
    for (int i = NUM_INSTRUCTIONS - 1; i >= 0; i--) begin
      if (!q[i].valid)
        free_idx = IW'(i);
      if (q[i].valid && q[i].rs1_rdy && q[i].rs2_rdy &&
          fu_rdy4[q[i].fu]) begin
        iss_idx = IW'(i);
        iss_hit = 1'b1;
      end
    end
  end

  // A same-cycle forward beats the dispatch-time value.
  always_comb begin
    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.rs1_tag = phys_rs1;
    new_e.rs2_tag = phys_rs2;
    new_e.dest    = phys_dest;
    new_e.opcode  = opcode;
    new_e.imm     = immediate;
    new_e.rob     = ROB_entry_index;
    new_e.fu      = fu_class(opcode);
    if (fwd_valid[0] && fwd_tag0 == phys_rs1) begin
      new_e.rs1_rdy = 1'b1;
      new_e.rs1_val = fwd_rs1;
    end else if (fwd_valid[1] && fwd_tag1 == phys_rs1) begin
      new_e.rs1_rdy = 1'b1;
      new_e.rs1_val = fwd_rs2;
    end else begin
      new_e.rs1_rdy = sb[phys_rs1];
      new_e.rs1_val = phys_rs1_val;
    end
    if (fwd_valid[0] && fwd_tag0 == phys_rs2) begin
      new_e.rs2_rdy = 1'b1;
      new_e.rs2_val = fwd_rs1;
    end else if (fwd_valid[1] && fwd_tag1 == phys_rs2) begin
      new_e.rs2_rdy = 1'b1;
      new_e.rs2_val = fwd_rs2;
    end else begin
      new_e.rs2_rdy = sb[phys_rs2];
      new_e.rs2_val = phys_rs2_val;
    end
  end

  // Dispatch clear applied last so it wins over a same-tag forward.
  always_comb begin
    sb_n = sb;
    if (fwd_valid[0])
      sb_n[fwd_tag0] = 1'b1;
    if (fwd_valid[1])
      sb_n[fwd_tag1] = 1'b1;
    if (accept && phys_dest != 6'd0)
      sb_n[phys_dest] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_INSTRUCTIONS; i++)
        q[i] <= '0;
      sb            <= '1;
      count         <= '0;
      issue_valid   <= 1'b0;
      issue_fu      <= '0;
      issue_opcode  <= '0;
      issue_dest    <= '0;
      issue_rob     <= '0;
      issue_rs1_val <= '0;
      issue_rs2_val <= '0;
      issue_imm     <= '0;
    end else begin
      for (int i = 0; i < NUM_INSTRUCTIONS; i++) begin
        if (q[i].valid && !q[i].rs1_rdy) begin
          if (fwd_valid[0] && fwd_tag0 == q[i].rs1_tag) begin
            q[i].rs1_rdy <= 1'b1;
            q[i].rs1_val <= fwd_rs1;
          end else if (fwd_valid[1] && fwd_tag1 == q[i].rs1_tag) begin
            q[i].rs1_rdy <= 1'b1;
            q[i].rs1_val <= fwd_rs2;
          end
        end
        if (q[i].valid && !q[i].rs2_rdy) begin
          if (fwd_valid[0] && fwd_tag0 == q[i].rs2_tag) begin
            q[i].rs2_rdy <= 1'b1;
            q[i].rs2_val <= fwd_rs1;
          end else if (fwd_valid[1] && fwd_tag1 == q[i].rs2_tag) begin
            q[i].rs2_rdy <= 1'b1;
            q[i].rs2_val <= fwd_rs2;
          end
        end
      end
      if (accept)
        q[free_idx] <= new_e;
      issue_valid <= iss_hit;
      if (iss_hit) begin
        q[iss_idx].valid <= 1'b0;
        issue_fu         <= q[iss_idx].fu;
        issue_opcode     <= q[iss_idx].opcode;
        issue_dest       <= q[iss_idx].dest;
        issue_rob        <= q[iss_idx].rob;
        issue_rs1_val    <= q[iss_idx].rs1_val;
        issue_rs2_val    <= q[iss_idx].rs2_val;
        issue_imm        <= q[iss_idx].imm;
      end
      sb    <= sb_n;
      count <= count + CW'(accept) - CW'(iss_hit);
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed table, corner sequences and random
// traffic against a queue-level reference model.
module tb_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_enable;
  logic [5:0]  phys_dest, phys_rs1, phys_rs2, ROB_entry_index;
  logic [31:0] phys_rs1_val, phys_rs2_val, immediate;
  logic [6:0]  opcode;
  logic [31:0] fwd_rs1, fwd_rs2;
  logic [1:0]  fwd_valid;
  logic [5:0]  fwd_tag0, fwd_tag1;
  logic [2:0]  fu_ready;
  logic        issue_queue_full, issue_valid;
  logic [1:0]  issue_fu;
  logic [6:0]  issue_opcode;
  logic [5:0]  issue_dest, issue_rob;
  logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm;

  always #5 clk = ~clk;

  issue_queue dut (
    .clk(clk), .reset(reset), .write_enable(write_enable),
    .phys_dest(phys_dest), .phys_rs1(phys_rs1),
    .phys_rs1_val(phys_rs1_val), .phys_rs2(phys_rs2),
    .phys_rs2_val(phys_rs2_val), .opcode(opcode),
    .immediate(immediate), .ROB_entry_index(ROB_entry_index),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_valid(fwd_valid),
    .fwd_tag0(fwd_tag0), .fwd_tag1(fwd_tag1), .fu_ready(fu_ready),
    .issue_queue_full(issue_queue_full), .issue_valid(issue_valid),
    .issue_fu(issue_fu), .issue_opcode(issue_opcode),
    .issue_dest(issue_dest), .issue_rob(issue_rob),
    .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
    .issue_imm(issue_imm)
  );

  localparam logic [6:0] OP_ADD = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  typedef struct {
    logic        we;
    logic [6:0]  op;
    logic [5:0]  dest, rs1, rs2, rob;
    logic [31:0] v1, v2, imm;
  } disp_t;

  function automatic disp_t mkd(logic we, logic [6:0] op, logic [5:0] dest,
                                logic [5:0] rs1, logic [31:0] v1,
                                logic [5:0] rs2, logic [31:0] v2,
                                logic [31:0] imm, logic [5:0] rob);
    disp_t d;
    d.we = we; d.op = op; d.dest = dest; d.rs1 = rs1; d.v1 = v1;
    d.rs2 = rs2; d.v2 = v2; d.imm = imm; d.rob = rob;
    return d;
  endfunction

  function automatic disp_t rnd_disp();
    disp_t d;
    logic [6:0] ops [8];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    d.we   = 1'b1;
    d.op   = ops[$urandom_range(0, 7)];
    d.dest = 6'($urandom_range(1, 63));
    d.rs1  = 6'd0;
    d.rs2  = 6'd0;
    d.v1   = $urandom;
    d.v2   = $urandom;
    d.imm  = $urandom;
    d.rob  = 6'($urandom);
    return d;
  endfunction

  task automatic drive(input disp_t d);
    write_enable    = d.we;
    opcode          = d.op;
    phys_dest       = d.dest;
    phys_rs1        = d.rs1;
    phys_rs1_val    = d.v1;
    phys_rs2        = d.rs2;
    phys_rs2_val    = d.v2;
    immediate       = d.imm;
    ROB_entry_index = d.rob;
  endtask

  // Reference model: a slot array, a ready bitmap and an occupancy count.
  typedef struct {
    bit          v;
    bit          r1, r2;
    logic [5:0]  t1, t2, d, rob;
    logic [31:0] v1, v2, imm;
    logic [6:0]  op;
  } ment_t;

  ment_t       mq [64];
  bit          msb [64];
  int          mcnt;
  logic        e_v;
  logic [1:0]  e_fu;
  logic [6:0]  e_op;
  logic [5:0]  e_d, e_rob;
  logic [31:0] e_1, e_2, e_imm;

  function automatic int m_cls(logic [6:0] op);
    if (op inside {7'b0000011, 7'b0100011}) return 1;
    if (op inside {7'b1100011, 7'b1101111, 7'b1100111}) return 2;
    return 0;
  endfunction

  function automatic void m_src(input logic [5:0] t, input logic [31:0] pv,
                                output bit r, output logic [31:0] v);
    if (fwd_valid[0] && fwd_tag0 == t) begin r = 1; v = fwd_rs1; end
    else if (fwd_valid[1] && fwd_tag1 == t) begin r = 1; v = fwd_rs2; end
    else begin r = msb[t]; v = pv; end
  endfunction

  function automatic void model_step();
    int iss = -1;
    int fr = -1;
    bit acc;
    ment_t n;
    if (reset) begin
      for (int i = 0; i < 64; i++) begin mq[i].v = 0; msb[i] = 1; end
      mcnt = 0;
      e_v = 0; e_fu = 0; e_op = 0; e_d = 0; e_rob = 0;
      e_1 = 0; e_2 = 0; e_imm = 0;
      return;
    end
    for (int i = 0; i < 64; i++)
      if (iss < 0 && mq[i].v && mq[i].r1 && mq[i].r2 &&
          fu_ready[m_cls(mq[i].op)])
        iss = i;
    acc = write_enable && (mcnt < 64);
    if (acc)
      for (int i = 0; i < 64; i++)
        if (fr < 0 && !mq[i].v) fr = i;
    e_v = (iss >= 0);
    if (iss >= 0) begin
      e_fu = 2'(m_cls(mq[iss].op)); e_op = mq[iss].op;
      e_d = mq[iss].d; e_rob = mq[iss].rob;
      e_1 = mq[iss].v1; e_2 = mq[iss].v2; e_imm = mq[iss].imm;
    end
    for (int i = 0; i < 64; i++) begin
      if (mq[i].v && !mq[i].r1) begin
        if (fwd_valid[0] && fwd_tag0 == mq[i].t1) begin
          mq[i].r1 = 1; mq[i].v1 = fwd_rs1;
        end else if (fwd_valid[1] && fwd_tag1 == mq[i].t1) begin
          mq[i].r1 = 1; mq[i].v1 = fwd_rs2;
        end
      end
      if (mq[i].v && !mq[i].r2) begin
        if (fwd_valid[0] && fwd_tag0 == mq[i].t2) begin
          mq[i].r2 = 1; mq[i].v2 = fwd_rs1;
        end else if (fwd_valid[1] && fwd_tag1 == mq[i].t2) begin
          mq[i].r2 = 1; mq[i].v2 = fwd_rs2;
        end
      end
    end
    if (iss >= 0) mq[iss].v = 0;
    if (acc) begin
      n.v = 1; n.t1 = phys_rs1; n.t2 = phys_rs2; n.d = phys_dest;
      n.rob = ROB_entry_index; n.imm = immediate; n.op = opcode;
      m_src(phys_rs1, phys_rs1_val, n.r1, n.v1);
      m_src(phys_rs2, phys_rs2_val, n.r2, n.v2);
      mq[fr] = n;
    end
    if (fwd_valid[0]) msb[fwd_tag0] = 1;
    if (fwd_valid[1]) msb[fwd_tag1] = 1;
    if (acc && phys_dest != 0) msb[phys_dest] = 0;
    mcnt = mcnt + int'(acc) - int'(iss >= 0);
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("mdl_valid", issue_valid, e_v);
    chk("mdl_full", issue_queue_full, mcnt == 64);
    chk("mdl_fu", issue_fu, e_fu);
    chk("mdl_op", issue_opcode, e_op);
    chk("mdl_dest", issue_dest, e_d);
    chk("mdl_rob", issue_rob, e_rob);
    chk("mdl_rs1", issue_rs1_val, e_1);
    chk("mdl_rs2", issue_rs2_val, e_2);
    chk("mdl_imm", issue_imm, e_imm);
  endtask

  typedef struct {
    disp_t       d;
    logic [2:0]  fu;
    logic        ev;
    logic [1:0]  efu;
    logic [6:0]  eop;
    logic [5:0]  edest, erob;
    logic [31:0] e1, e2, eimm;
    logic        efull;
  } vec_t;

  function automatic vec_t mkv(disp_t d, logic [2:0] fu, logic ev,
                               logic [1:0] efu, logic [6:0] eop,
                               logic [5:0] edest, logic [5:0] erob,
                               logic [31:0] e1, logic [31:0] e2,
                               logic [31:0] eimm);
    vec_t v;
    v.d = d; v.fu = fu; v.ev = ev; v.efu = efu; v.eop = eop;
    v.edest = edest; v.erob = erob; v.e1 = e1; v.e2 = e2;
    v.eimm = eimm; v.efull = 1'b0;
    return v;
  endfunction

  vec_t  tbl [9];
  disp_t idle;
  disp_t first, late, da, db, dc;
  int    pulses;
  bit    seen;

  initial begin
    idle = mkd(0, 7'd0, 6'd0, 6'd0, 0, 6'd0, 0, 0, 6'd0);
    tbl[0] = mkv(mkd(1, OP_ADD, 6'd1, 6'd2, 42, 6'd3, 17, 0, 6'd1),
                 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mkv(mkd(1, OP_ADD, 6'd4, 6'd5, 7, 6'd6, 3, 0, 6'd2),
                 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2] = mkv(mkd(1, OP_LW, 6'd7, 6'd8, 100, 6'd0, 0, 8, 6'd3),
                 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3] = mkv(mkd(1, OP_SW, 6'd0, 6'd9, 200, 6'd10, 55, 16, 6'd4),
                 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4] = mkv(idle, 3'b111, 1, 0, OP_ADD, 6'd1, 6'd1, 42, 17, 0);
    tbl[5] = mkv(idle, 3'b111, 1, 0, OP_ADD, 6'd4, 6'd2, 7, 3, 0);
    tbl[6] = mkv(idle, 3'b111, 1, 1, OP_LW, 6'd7, 6'd3, 100, 0, 8);
    tbl[7] = mkv(idle, 3'b111, 1, 1, OP_SW, 6'd0, 6'd4, 200, 55, 16);
    tbl[8] = mkv(idle, 3'b111, 0, 1, OP_SW, 6'd0, 6'd4, 200, 55, 16);

    reset = 1; drive(idle); fu_ready = 0;
    fwd_valid = 0; fwd_tag0 = 0; fwd_tag1 = 0; fwd_rs1 = 0; fwd_rs2 = 0;
    tick(); tick();
    chk("rst_valid", issue_valid, 0);
    chk("rst_full", issue_queue_full, 0);
    reset = 0;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].d);
      fu_ready = tbl[i].fu;
      tick();
      chk($sformatf("v%0d_valid", i), issue_valid, tbl[i].ev);
      chk($sformatf("v%0d_fu", i), issue_fu, tbl[i].efu);
      chk($sformatf("v%0d_op", i), issue_opcode, tbl[i].eop);
      chk($sformatf("v%0d_dest", i), issue_dest, tbl[i].edest);
      chk($sformatf("v%0d_rob", i), issue_rob, tbl[i].erob);
      chk($sformatf("v%0d_rs1", i), issue_rs1_val, tbl[i].e1);
      chk($sformatf("v%0d_rs2", i), issue_rs2_val, tbl[i].e2);
      chk($sformatf("v%0d_imm", i), issue_imm, tbl[i].eimm);
      chk($sformatf("v%0d_full", i), issue_queue_full, tbl[i].efull);
    end

    // Fill past capacity with nothing able to issue.
    fu_ready = 0;
    for (int i = 0; i < 68; i++) begin
      disp_t d;
      d = rnd_disp();
      if (i == 0) first = d;
      drive(d);
      tick();
      chk($sformatf("fill%0d_full", i), issue_queue_full, i >= 63);
    end

    // Full plus free FU: write rejected, oldest slot issues.
    late = rnd_disp();
    drive(late);
    fu_ready = 3'b111;
    tick();
    chk("fi_valid", issue_valid, 1);
    chk("fi_rs1", issue_rs1_val, first.v1);
    chk("fi_imm", issue_imm, first.imm);
    chk("fi_full", issue_queue_full, 0);
    // Freed slot 0 accepts the retried write.
    fu_ready = 0;
    tick();
    chk("fw_valid", issue_valid, 0);
    chk("fw_full", issue_queue_full, 1);

    drive(idle);
    fu_ready = 3'b111;
    pulses = 0;
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (issue_valid) begin
        if (!seen) begin
          chk("late_imm", issue_imm, late.imm);
          chk("late_rs2", issue_rs2_val, late.v2);
          seen = 1;
        end
        pulses++;
      end
    end
    chk("drain_count", pulses, 64);
    chk("drain_full", issue_queue_full, 0);

    // Dependent op waits for forwarding of its producer's tag.
    da = mkd(1, OP_ADD, 6'd10, 6'd0, 5, 6'd0, 6, 0, 6'd11);
    db = mkd(1, OP_ADD, 6'd20, 6'd10, 999, 6'd0, 3, 0, 6'd12);
    drive(da); tick();
    chk("dep_a0", issue_valid, 0);
    drive(db); tick();
    chk("dep_a_issue", issue_valid, 1);
    chk("dep_a_dest", issue_dest, 10);
    drive(idle); tick();
    chk("dep_b_wait", issue_valid, 0);
    fwd_valid = 2'b01; fwd_tag0 = 6'd10; fwd_rs1 = 32'hDEAD;
    tick();
    chk("dep_b_wake", issue_valid, 0);
    fwd_valid = 0;
    tick();
    chk("dep_b_issue", issue_valid, 1);
    chk("dep_b_dest", issue_dest, 20);
    chk("dep_b_rs1", issue_rs1_val, 32'hDEAD);
    chk("dep_b_rs2", issue_rs2_val, 3);

    // Reset with pending entries and busy tags.
    fu_ready = 0;
    for (int i = 0; i < 64; i++) begin
      disp_t d;
      d = rnd_disp();
      if (i == 0) d.dest = 6'd33;
      drive(d);
      tick();
    end
    chk("pre_rst_full", issue_queue_full, 1);
    reset = 1;
    drive(rnd_disp());
    fu_ready = 3'b111;
    tick();
    chk("rst2_valid", issue_valid, 0);
    chk("rst2_full", issue_queue_full, 0);
    chk("rst2_rs1", issue_rs1_val, 0);
    chk("rst2_imm", issue_imm, 0);
    chk("rst2_fu", issue_fu, 0);
    reset = 0;
    dc = mkd(1, OP_ADD, 6'd40, 6'd33, 77, 6'd0, 1, 0, 6'd5);
    drive(dc); tick();
    chk("rst2_c0", issue_valid, 0);
    drive(idle); tick();
    chk("rst2_c_issue", issue_valid, 1);
    chk("rst2_c_rs1", issue_rs1_val, 77);
    tick();
    chk("rst2_empty", issue_valid, 0);

    // Random traffic with dense tag reuse.
    for (int i = 0; i < 900; i++) begin
      disp_t d;
      d = rnd_disp();
      d.we   = ($urandom_range(0, 3) != 0);
      d.dest = 6'($urandom_range(0, 15));
      d.rs1  = 6'($urandom_range(0, 15));
      d.rs2  = 6'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) d.op = 7'($urandom);
      drive(d);
      fwd_valid = 2'($urandom);
      fwd_tag0  = 6'($urandom_range(0, 15));
      fwd_tag1  = 6'($urandom_range(0, 15));
      fwd_rs1   = $urandom;
      fwd_rs2   = $urandom;
      fu_ready  = 3'($urandom);
      reset     = (i == 450);
      tick();
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
